secded_batch_ctrl: RTL and testbench

// Hardware sequencer for batch Hamming SECDED decode (program-2 workload) without CPU intervention.
// On a req pulse it walks NUM_WORDS 16-bit encoded words in byte-wide data memory.
// It decodes/corrects each word and writes the 16-bit result back. It then raises done.
// It sits beside top_level's data memory as a second master, muxed in by the memory arbiter via busy.

---
 rtl/secded_batch_ctrl_pkg.sv | 23 ++
 rtl/secded_batch_ctrl_if.sv | 25 ++
 rtl/secded_batch_ctrl_dec.sv | 37 +++
 rtl/secded_batch_ctrl.sv | 129 ++++++++++++
 tb/tb_secded_batch_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/secded_batch_ctrl_pkg.sv
// Shared types for the batch SECDED sequencer: FSM states, decode flags and
// the codeword-to-data extraction used by both the decoder and the ISA datapath.
package secded_batch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [1:0] FLG_NONE = 2'b00;
    localparam logic [1:0] FLG_SGL  = 2'b01;
    localparam logic [1:0] FLG_DBL  = 2'b10;

    // Data bits sit at the non-power-of-two codeword positions.
    function automatic logic [11:1] extract_data(input logic [15:0] c);
        return {c[15:9], c[7:5], c[3]};
    endfunction

endpackage

// File: rtl/secded_batch_ctrl_if.sv
// Request/status and byte-wide memory port of the batch SECDED sequencer.
// master = the sequencer, slave = the host/arbiter side.
interface secded_batch_ctrl_if #(
    parameter int AW = 8
);
    logic          req;
    logic          done;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic [7:0]    mem_wr_data;
    logic          mem_wr_en;
    logic [7:0]    n_single;
    logic [7:0]    n_double;

    modport master (
        input  req, mem_rd_data,
        output done, busy, mem_addr, mem_wr_data, mem_wr_en, n_single, n_double
    );

    modport slave (
        output req, mem_rd_data,
        input  done, busy, mem_addr, mem_wr_data, mem_wr_en, n_single, n_double
    );
endinterface

// File: rtl/secded_batch_ctrl_dec.sv
// Combinational Hamming(16,11) SECDED decoder: corrects single errors, flags doubles.
// Result layout is {flags, 3'b000, data[11:1]}.
module hamming_secded_dec
    import secded_batch_ctrl_pkg::*;
(
    input  logic [15:0] w,
    output logic [15:0] res,
    output logic        is_sgl,
    output logic        is_dbl
);

    logic [3:0]  s;
    logic        p;
    logic [15:0] c;
    logic [1:0]  flags;

    always_comb begin
        s = '0;
        for (int j = 1; j < 16; j++) begin
            if (w[j]) s = s ^ 4'(j);
        end
        p     = ^w;
        c     = w;
        flags = FLG_NONE;
        // Odd overall parity means one flipped bit; s==0 points at the p0 bit itself.
        if (p) begin
            flags = FLG_SGL;
            c[s]  = ~w[s];
        end else if (s != 4'd0) begin
            flags = FLG_DBL;
        end
        res    = {flags, 3'b000, extract_data(c)};
        is_sgl = (flags == FLG_SGL);
        is_dbl = (flags == FLG_DBL);
    end

endmodule

// File: rtl/secded_batch_ctrl.sv
// Batch SECDED sequencer: reads NUM_WORDS codewords byte by byte, decodes them
// and writes the results back, four cycles per word, then holds done.
module secded_batch_ctrl
    import secded_batch_ctrl_pkg::*;
#(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic                clk,
    input  logic                reset,
    secded_batch_ctrl_if.master bus
);

    localparam int IW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int SRC_END = SRC_BASE + 2 * NUM_WORDS - 1;
    localparam int DST_END = DST_BASE + 2 * NUM_WORDS - 1;

    if (NUM_WORDS < 1 || SRC_END >= 2 ** AW || DST_END >= 2 ** AW) begin : g_range_err
        $fatal(1, "secded_batch_ctrl: buffer exceeds address space");
    end
    if (SRC_BASE <= DST_END && DST_BASE <= SRC_END) begin : g_overlap_err
        $fatal(1, "secded_batch_ctrl: source and destination ranges overlap");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   w_q, w_d;
    logic          done_q, done_d;
    logic [7:0]    n_single_q, n_single_d;
    logic [7:0]    n_double_q, n_double_d;

    logic [15:0]   res;
    logic          is_sgl, is_dbl;
    logic [AW-1:0] src_addr, dst_addr;
    logic          last;

    hamming_secded_dec u_dec (
        .w      (w_q),
        .res    (res),
        .is_sgl (is_sgl),
        .is_dbl (is_dbl)
    );

    assign src_addr = AW'(SRC_BASE + 2 * int'(idx_q));
    assign dst_addr = AW'(DST_BASE + 2 * int'(idx_q));
    assign last     = (idx_q == IW'(NUM_WORDS - 1));

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        w_d             = w_q;
        done_d          = done_q;
        n_single_d      = n_single_q;
        n_double_d      = n_double_q;
        bus.busy        = 1'b1;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                bus.busy = 1'b0;
                // done rises one cycle after DONE is entered, unless a new req lands first.
                if (state_q == DONE) done_d = 1'b1;
                if (bus.req) begin
                    done_d     = 1'b0;
                    idx_d      = '0;
                    n_single_d = '0;
                    n_double_d = '0;
                    state_d    = RD_LO;
                end
            end
            RD_LO: begin
                bus.mem_addr = src_addr;
                w_d[7:0]     = bus.mem_rd_data;
                state_d      = RD_HI;
            end
            RD_HI: begin
                bus.mem_addr = src_addr + AW'(1);
                w_d[15:8]    = bus.mem_rd_data;
                state_d      = WR_LO;
            end
            WR_LO: begin
                bus.mem_addr    = dst_addr;
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = res[7:0];
                state_d         = WR_HI;
            end
            WR_HI: begin
                bus.mem_addr    = dst_addr + AW'(1);
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = res[15:8];
                if (is_sgl && n_single_q != 8'hFF) n_single_d = n_single_q + 8'd1;
                if (is_dbl && n_double_q != 8'hFF) n_double_d = n_double_q + 8'd1;
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = RD_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            w_q        <= '0;
            done_q     <= 1'b0;
            n_single_q <= '0;
            n_double_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            w_q        <= w_d;
            done_q     <= done_d;
            n_single_q <= n_single_d;
            n_double_q <= n_double_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.n_single = n_single_q;
    assign bus.n_double = n_double_q;

endmodule

// File: tb/tb_secded_batch_ctrl.sv
// Directed bench for secded_batch_ctrl with a byte memory model and
// independent encoder / flip-tracking expectations.
module tb_secded_batch_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    secded_batch_ctrl_if #(.AW(8)) bus ();

    secded_batch_ctrl #(
        .NUM_WORDS(15), .SRC_BASE(30), .DST_BASE(0), .AW(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  src_mem [256];
    logic [7:0]  dst_mem [256];
    logic [15:0] cw_tab  [15];
    logic [15:0] exp_tab [15];

    assign bus.mem_rd_data = src_mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr_en) dst_mem[bus.mem_addr] <= bus.mem_wr_data;
    end

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        c = '0;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[15:9] = d[10:4];
        c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
        c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        c[4] = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        c[8] = ^c[15:9];
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Data bit disturbed by flipping a codeword position (0 for parity positions).
    function automatic logic [10:0] dmask(input int pos);
        logic [10:0] m;
        m = '0;
        case (pos)
            3: m[0] = 1'b1;
            5: m[1] = 1'b1;
            6: m[2] = 1'b1;
            7: m[3] = 1'b1;
            default: if (pos >= 9) m[pos - 5] = 1'b1;
        endcase
        return m;
    endfunction

    task automatic load_words();
        for (int i = 0; i < 15; i++) begin
            src_mem[30 + 2 * i]     = cw_tab[i][7:0];
            src_mem[30 + 2 * i + 1] = cw_tab[i][15:8];
        end
    endtask

    // Starts a batch and counts edges until done; req is re-pulsed at lat==ra/rb.
    task automatic run_batch(input int ra, input int rb, output int lat);
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            bus.req = (lat == ra) || (lat == rb);
            @(posedge clk);
            #1;
            lat++;
        end
        bus.req = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got done=%b busy=%b wr_en=%b exp 0/0/0",
                     bus.done, bus.busy, bus.mem_wr_en);
        end
        checks++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_bus got addr=%h wdata=%h exp 00/00", bus.mem_addr, bus.mem_wr_data);
        end
        checks++;
        if (bus.n_single !== 8'h00 || bus.n_double !== 8'h00) begin
            failures++;
            $display("FAIL reset_cnt got s=%0d d=%0d exp 0/0", bus.n_single, bus.n_double);
        end
    endtask

    task automatic test_clean();
        int lat;
        logic [10:0] d;
        for (int i = 0; i < 15; i++) begin
            d = 11'h5A5 ^ 11'(i * 137);
            cw_tab[i]  = encode(d);
            exp_tab[i] = {5'b00000, d};
        end
        load_words();
        run_batch(-1, -1, lat);
        checks++;
        if (lat !== 61) begin
            failures++;
            $display("FAIL clean_latency got=%0d exp=61", lat);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if ({dst_mem[2 * i + 1], dst_mem[2 * i]} !== exp_tab[i]) begin
                failures++;
                $display("FAIL clean_word%0d got=%h exp=%h", i, {dst_mem[2 * i + 1], dst_mem[2 * i]}, exp_tab[i]);
            end
        end
        checks++;
        if (bus.n_single !== 8'd0 || bus.n_double !== 8'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL clean_cnt got s=%0d d=%0d busy=%b exp 0/0/0", bus.n_single, bus.n_double, bus.busy);
        end
    endtask

    task automatic test_single();
        int lat;
        logic [10:0] d;
        for (int i = 0; i < 15; i++) begin
            d = (i < 2) ? 11'h7FF : 11'(i * 291 + 5);
            cw_tab[i]  = encode(d) ^ (16'h1 << ((i == 0) ? 6 : (i == 1) ? 0 : i));
            exp_tab[i] = {5'b01000, d};
        end
        load_words();
        run_batch(-1, -1, lat);
        checks++;
        if ({dst_mem[1], dst_mem[0]} !== 16'h47FF || {dst_mem[3], dst_mem[2]} !== 16'h47FF) begin
            failures++;
            $display("FAIL single_7ff got=%h,%h exp=47ff,47ff", {dst_mem[1], dst_mem[0]}, {dst_mem[3], dst_mem[2]});
        end
        for (int i = 2; i < 15; i++) begin
            checks++;
            if ({dst_mem[2 * i + 1], dst_mem[2 * i]} !== exp_tab[i]) begin
                failures++;
                $display("FAIL single_word%0d got=%h exp=%h", i, {dst_mem[2 * i + 1], dst_mem[2 * i]}, exp_tab[i]);
            end
        end
        checks++;
        if (bus.n_single !== 8'd15 || bus.n_double !== 8'd0) begin
            failures++;
            $display("FAIL single_cnt got s=%0d d=%0d exp 15/0", bus.n_single, bus.n_double);
        end
    endtask

    // Leaves the controller in DONE with n_single nonzero from the previous test.
    task automatic test_req_in_done();
        int lat;
        checks++;
        if (bus.done !== 1'b1 || bus.n_single !== 8'd15) begin
            failures++;
            $display("FAIL done_hold got done=%b s=%0d exp 1/15", bus.done, bus.n_single);
        end
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.n_single !== 8'd0) begin
            failures++;
            $display("FAIL done_rearm got done=%b busy=%b s=%0d exp 0/1/0", bus.done, bus.busy, bus.n_single);
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 61 || bus.n_single !== 8'd15) begin
            failures++;
            $display("FAIL done_rerun got lat=%0d s=%0d exp 61/15", lat, bus.n_single);
        end
    endtask

    task automatic test_double();
        int lat;
        logic [10:0] d;
        for (int i = 0; i < 15; i++) begin
            d = (i == 0) ? 11'h7FF : 11'(i * 77);
            cw_tab[i]  = encode(d);
            exp_tab[i] = {5'b00000, d};
        end
        cw_tab[0] = cw_tab[0] ^ 16'h0408;
        load_words();
        run_batch(-1, -1, lat);
        checks++;
        if ({dst_mem[1], dst_mem[0]} !== 16'h87DE) begin
            failures++;
            $display("FAIL double_word0 got=%h exp=87de", {dst_mem[1], dst_mem[0]});
        end
        checks++;
        if ({dst_mem[5], dst_mem[4]} !== exp_tab[2]) begin
            failures++;
            $display("FAIL double_word2 got=%h exp=%h", {dst_mem[5], dst_mem[4]}, exp_tab[2]);
        end
        checks++;
        if (bus.n_double !== 8'd1 || bus.n_single !== 8'd0) begin
            failures++;
            $display("FAIL double_cnt got s=%0d d=%0d exp 0/1", bus.n_single, bus.n_double);
        end
    endtask

    task automatic test_random();
        int lat, p1, p2, r, exp_s, exp_d, score;
        logic [10:0] d;
        exp_s = 0;
        exp_d = 0;
        score = 0;
        for (int i = 0; i < 15; i++) begin
            d  = 11'($urandom);
            r  = $urandom_range(0, 3);
            p1 = $urandom_range(0, 15);
            p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
            if (r == 0) begin
                cw_tab[i]  = encode(d);
                exp_tab[i] = {5'b00000, d};
            end else if (r == 3) begin
                cw_tab[i]  = encode(d) ^ (16'h1 << p1) ^ (16'h1 << p2);
                exp_tab[i] = {5'b10000, d ^ dmask(p1) ^ dmask(p2)};
                exp_d++;
            end else begin
                cw_tab[i]  = encode(d) ^ (16'h1 << p1);
                exp_tab[i] = {5'b01000, d};
                exp_s++;
            end
        end
        load_words();
        run_batch(-1, -1, lat);
        for (int i = 0; i < 15; i++) begin
            if ({dst_mem[2 * i + 1], dst_mem[2 * i]} === exp_tab[i]) score++;
            else $display("FAIL random_word%0d got=%h exp=%h", i, {dst_mem[2 * i + 1], dst_mem[2 * i]}, exp_tab[i]);
        end
        checks++;
        if (score !== 15) begin
            failures++;
            $display("FAIL random_score got=%0d exp=15", score);
        end
        checks++;
        if (bus.n_single !== 8'(exp_s) || bus.n_double !== 8'(exp_d)) begin
            failures++;
            $display("FAIL random_cnt got s=%0d d=%0d exp %0d/%0d", bus.n_single, bus.n_double, exp_s, exp_d);
        end
    endtask

    task automatic test_reset_mid();
        int n, lat;
        logic [10:0] d;
        for (int i = 0; i < 15; i++) cw_tab[i] = encode(11'(i * 5 + 1));
        load_words();
        @(negedge clk);
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        n = 0;
        while (!(bus.mem_wr_en === 1'b1 && bus.mem_addr === 8'd14) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL midrst_reach got=timeout exp=WR_LO of word 7");
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_addr !== 8'h00) begin
            failures++;
            $display("FAIL midrst_state got wr_en=%b busy=%b done=%b addr=%h exp 0/0/0/00",
                     bus.mem_wr_en, bus.busy, bus.done, bus.mem_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            d = 11'h3C3 ^ 11'(i * 201);
            cw_tab[i]  = encode(d);
            exp_tab[i] = {5'b00000, d};
        end
        load_words();
        run_batch(-1, -1, lat);
        checks++;
        if (lat !== 61) begin
            failures++;
            $display("FAIL midrst_latency got=%0d exp=61", lat);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if ({dst_mem[2 * i + 1], dst_mem[2 * i]} !== exp_tab[i]) begin
                failures++;
                $display("FAIL midrst_word%0d got=%h exp=%h", i, {dst_mem[2 * i + 1], dst_mem[2 * i]}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_req_while_busy();
        int lat;
        logic [10:0] d;
        for (int i = 0; i < 15; i++) begin
            d = 11'h0F0 + 11'(i * 3);
            cw_tab[i]  = encode(d);
            exp_tab[i] = {5'b00000, d};
        end
        load_words();
        run_batch(10, 59, lat);
        checks++;
        if (lat !== 61) begin
            failures++;
            $display("FAIL busyreq_latency got=%0d exp=61", lat);
        end
        checks++;
        if ({dst_mem[29], dst_mem[28]} !== exp_tab[14] || {dst_mem[5], dst_mem[4]} !== exp_tab[2]) begin
            failures++;
            $display("FAIL busyreq_data got=%h,%h exp=%h,%h", {dst_mem[29], dst_mem[28]},
                     {dst_mem[5], dst_mem[4]}, exp_tab[14], exp_tab[2]);
        end
    endtask

    initial begin
        bus.req = 1'b0;
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_clean();
        test_single();
        test_req_in_done();
        test_double();
        test_random();
        test_reset_mid();
        test_req_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
